// File: rtl/mpi_eth_interface.sv
// MPI-over-Ethernet blocking send endpoint: emits a SEND frame, a DONE_REQ frame,
// then waits on the RX stream for a matching DONE_ACK before accepting the next command.
module mpi_eth_interface #(
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter logic [7:0]  T_SEND     = 8'h01,
  parameter logic [7:0]  T_DONE_REQ = 8'h02,
  parameter logic [7:0]  T_DONE_ACK = 8'h03
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_dst_rank,
  input  logic [7:0]  cmd_src_rank,
  input  logic [31:0] cmd_size,
  input  logic [47:0] cmd_mac_dst,
  input  logic [47:0] cmd_mac_src,
  input  logic [31:0] cmd_ip_dst,
  input  logic [31:0] cmd_ip_src,
  input  logic [63:0] pld_data,
  input  logic [7:0]  pld_keep,
  input  logic        pld_last,
  input  logic        pld_valid,
  output logic        pld_ready,
  output logic [63:0] stream_out_data,
  output logic [7:0]  stream_out_keep,
  output logic        stream_out_last,
  output logic        stream_out_valid,
  input  logic        stream_out_ready,
  input  logic [63:0] stream_in_data,
  input  logic [7:0]  stream_in_keep,
  input  logic        stream_in_last,
  input  logic        stream_in_valid,
  output logic        stream_in_ready,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHDR,
    S_SPLD,
    S_RHDR,
    S_WAIT_ACK
  } state_t;

  state_t      state_q;
  logic [1:0]  hdr_idx_q;
  logic [7:0]  msg_type_q;
  logic [15:0] dst_rank_q;
  logic [7:0]  src_rank_q;
  logic [31:0] size_q;
  logic [47:0] mac_dst_q;
  logic [47:0] mac_src_q;
  logic [31:0] ip_dst_q;
  logic [31:0] ip_src_q;
  logic [63:0] tx_data_q;
  logic [7:0]  tx_keep_q;
  logic        tx_last_q;
  logic        tx_valid_q;
  logic        done_q;
  logic [2:0]  rx_cnt_q;
  logic [47:0] rx_mac_q;

  logic [1:0]  nidx_d;
  logic [31:0] hdr_size_d;
  logic [63:0] next_hdr_d;
  logic        ack_match_d;
  logic        in_spld;
  logic        unused_ok;

  always_comb begin
    nidx_d     = hdr_idx_q + 2'd1;
    hdr_size_d = (msg_type_q == T_SEND) ? size_q : '0;
    case (nidx_d)
      2'd1:    next_hdr_d = {mac_src_q[31:0], ETHERTYPE, 8'h00, msg_type_q};
      2'd2:    next_hdr_d = {ip_dst_q, ip_src_q};
      2'd3:    next_hdr_d = {dst_rank_q, src_rank_q, msg_type_q, hdr_size_d};
      default: next_hdr_d = {mac_dst_q, mac_src_q[47:32]};
    endcase
  end

  // The last RX beat must be flit 3; its rank/type fields are compared straight off the bus.
  always_comb begin
    ack_match_d = stream_in_valid && stream_in_last && (rx_cnt_q == 3'd3)
               && (rx_mac_q == mac_src_q)
               && (stream_in_data[39:32] == T_DONE_ACK)
               && (stream_in_data[63:48] == {8'h00, src_rank_q})
               && (stream_in_data[47:40] == dst_rank_q[7:0]);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      hdr_idx_q  <= '0;
      msg_type_q <= '0;
      dst_rank_q <= '0;
      src_rank_q <= '0;
      size_q     <= '0;
      mac_dst_q  <= '0;
      mac_src_q  <= '0;
      ip_dst_q   <= '0;
      ip_src_q   <= '0;
      tx_data_q  <= '0;
      tx_keep_q  <= '0;
      tx_last_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            dst_rank_q <= cmd_dst_rank;
            src_rank_q <= cmd_src_rank;
            size_q     <= cmd_size;
            mac_dst_q  <= cmd_mac_dst;
            mac_src_q  <= cmd_mac_src;
            ip_dst_q   <= cmd_ip_dst;
            ip_src_q   <= cmd_ip_src;
            msg_type_q <= T_SEND;
            hdr_idx_q  <= '0;
            tx_data_q  <= {cmd_mac_dst, cmd_mac_src[47:32]};
            tx_keep_q  <= '1;
            tx_last_q  <= 1'b0;
            tx_valid_q <= 1'b1;
            state_q    <= S_SHDR;
          end
        end
        S_SHDR: begin
          if (stream_out_ready) begin
            if (hdr_idx_q == 2'd3) begin
              tx_valid_q <= 1'b0;
              tx_data_q  <= '0;
              tx_keep_q  <= '0;
              state_q    <= S_SPLD;
            end else begin
              hdr_idx_q <= nidx_d;
              tx_data_q <= next_hdr_d;
            end
          end
        end
        S_SPLD: begin
          if (pld_valid && stream_out_ready && pld_last) begin
            msg_type_q <= T_DONE_REQ;
            hdr_idx_q  <= '0;
            tx_data_q  <= {mac_dst_q, mac_src_q[47:32]};
            tx_keep_q  <= '1;
            tx_last_q  <= 1'b0;
            tx_valid_q <= 1'b1;
            state_q    <= S_RHDR;
          end
        end
        S_RHDR: begin
          if (stream_out_ready) begin
            if (hdr_idx_q == 2'd3) begin
              tx_valid_q <= 1'b0;
              tx_last_q  <= 1'b0;
              tx_data_q  <= '0;
              tx_keep_q  <= '0;
              state_q    <= S_WAIT_ACK;
            end else begin
              hdr_idx_q <= nidx_d;
              tx_data_q <= next_hdr_d;
              tx_last_q <= (nidx_d == 2'd3);
            end
          end
        end
        default: begin
          if (ack_match_d) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  // RX framing runs in every state so a frame already in flight still counts in WAIT_ACK.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      rx_cnt_q <= '0;
      rx_mac_q <= '0;
    end else if (stream_in_valid) begin
      if (rx_cnt_q == 3'd0) rx_mac_q <= stream_in_data[63:16];
      if (stream_in_last)          rx_cnt_q <= '0;
      else if (rx_cnt_q != 3'd4)   rx_cnt_q <= rx_cnt_q + 3'd1;
    end
  end

  assign in_spld          = (state_q == S_SPLD);
  assign stream_out_data  = in_spld ? pld_data  : tx_data_q;
  assign stream_out_keep  = in_spld ? pld_keep  : tx_keep_q;
  assign stream_out_last  = in_spld ? pld_last  : tx_last_q;
  assign stream_out_valid = in_spld ? pld_valid : tx_valid_q;
  assign pld_ready        = in_spld && stream_out_ready;
  assign cmd_ready        = aresetn && (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign stream_in_ready  = 1'b1;
  assign unused_ok        = ^{stream_in_keep, stream_in_data[15:0]};

endmodule

// File: tb/tb_mpi_eth_interface.sv
// Scoreboard bench for mpi_eth_interface: expected TX beats are queued as each
// transaction is set up and popped by a negedge monitor on every TX handshake.
module tb_mpi_eth_interface;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_dst_rank;
  logic [7:0]  cmd_src_rank;
  logic [31:0] cmd_size;
  logic [47:0] cmd_mac_dst, cmd_mac_src;
  logic [31:0] cmd_ip_dst, cmd_ip_src;
  logic [63:0] pld_data;
  logic [7:0]  pld_keep;
  logic        pld_last, pld_valid, pld_ready;
  logic [63:0] stream_out_data;
  logic [7:0]  stream_out_keep;
  logic        stream_out_last, stream_out_valid, stream_out_ready;
  logic [63:0] stream_in_data;
  logic [7:0]  stream_in_keep;
  logic        stream_in_last, stream_in_valid, stream_in_ready;
  logic        done, busy;

  always #5 clk = ~clk;

  mpi_eth_interface #(
    .ETHERTYPE  (16'h88B5),
    .T_SEND     (8'h01),
    .T_DONE_REQ (8'h02),
    .T_DONE_ACK (8'h03)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dst_rank(cmd_dst_rank), .cmd_src_rank(cmd_src_rank), .cmd_size(cmd_size),
    .cmd_mac_dst(cmd_mac_dst), .cmd_mac_src(cmd_mac_src),
    .cmd_ip_dst(cmd_ip_dst), .cmd_ip_src(cmd_ip_src),
    .pld_data(pld_data), .pld_keep(pld_keep), .pld_last(pld_last),
    .pld_valid(pld_valid), .pld_ready(pld_ready),
    .stream_out_data(stream_out_data), .stream_out_keep(stream_out_keep),
    .stream_out_last(stream_out_last), .stream_out_valid(stream_out_valid),
    .stream_out_ready(stream_out_ready),
    .stream_in_data(stream_in_data), .stream_in_keep(stream_in_keep),
    .stream_in_last(stream_in_last), .stream_in_valid(stream_in_valid),
    .stream_in_ready(stream_in_ready),
    .done(done), .busy(busy)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        pld;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] pl_data[$];
  logic [7:0]  pl_keep[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned tx_beats = 0;
  logic        bp = 1'b0;

  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;

  // Free-running backpressure pattern: ready alternates every cycle while bp is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp) stream_out_ready = ~stream_out_ready;
    end
  end

  always @(negedge clk) begin
    beat_t e;
    logic  exp_pr;
    if (aresetn !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (stream_out_valid !== 1'b1 || stream_out_data !== prev_data ||
            stream_out_keep !== prev_keep || stream_out_last !== prev_last)
          $display("FAIL stall_stable: got v=%b d=%h k=%h l=%b, need v=1 d=%h k=%h l=%b",
                   stream_out_valid, stream_out_data, stream_out_keep, stream_out_last,
                   prev_data, prev_keep, prev_last);
        else n_pass++;
      end
      if (exp_q.size() > 0) begin
        exp_pr = exp_q[0].pld ? stream_out_ready : 1'b0;
        n_checks++;
        if (pld_ready !== exp_pr)
          $display("FAIL pld_ready: got %b, need %b", pld_ready, exp_pr);
        else n_pass++;
      end
      if (stream_out_valid === 1'b1 && stream_out_ready === 1'b1) begin
        tx_beats++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL tx_unexpected: got d=%h l=%b, need no beat", stream_out_data, stream_out_last);
        end else begin
          e = exp_q.pop_front();
          if (stream_out_data !== e.data || stream_out_keep !== e.keep || stream_out_last !== e.last)
            $display("FAIL tx_beat: got d=%h k=%h l=%b, need d=%h k=%h l=%b",
                     stream_out_data, stream_out_keep, stream_out_last, e.data, e.keep, e.last);
          else n_pass++;
        end
      end
      prev_stall = (stream_out_valid === 1'b1) && (stream_out_ready !== 1'b1);
      prev_data  = stream_out_data;
      prev_keep  = stream_out_keep;
      prev_last  = stream_out_last;
    end
  end

  function automatic beat_t hb(input logic [63:0] d, input logic l);
    beat_t b;
    b.data = d; b.keep = 8'hFF; b.last = l; b.pld = 1'b0;
    return b;
  endfunction

  // Reference header built from the bench's own copy of the command fields.
  task automatic push_frame(input logic [7:0] typ, input logic [31:0] size);
    exp_q.push_back(hb({cmd_mac_dst, cmd_mac_src[47:32]}, 1'b0));
    exp_q.push_back(hb({cmd_mac_src[31:0], 16'h88B5, 8'h00, typ}, 1'b0));
    exp_q.push_back(hb({cmd_ip_dst, cmd_ip_src}, 1'b0));
    exp_q.push_back(hb({cmd_dst_rank, cmd_src_rank, typ, size}, typ == 8'h02));
  endtask

  task automatic push_payload();
    beat_t b;
    for (int i = 0; i < pl_data.size(); i++) begin
      b.data = pl_data[i]; b.keep = pl_keep[i]; b.last = (i == pl_data.size() - 1); b.pld = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic set_cmd(input logic [15:0] dst, input logic [7:0] src, input logic [31:0] size,
                         input logic [47:0] md, input logic [47:0] ms,
                         input logic [31:0] ipd, input logic [31:0] ips);
    cmd_dst_rank = dst; cmd_src_rank = src; cmd_size = size;
    cmd_mac_dst = md; cmd_mac_src = ms; cmd_ip_dst = ipd; cmd_ip_src = ips;
  endtask

  task automatic issue_cmd();
    bit ok = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_checks++;
    if (!ok || stream_out_valid !== 1'b1)
      $display("FAIL cmd_accept: got accepted=%0d valid=%b, need 1 1", ok, stream_out_valid);
    else n_pass++;
  endtask

  task automatic drive_payload();
    for (int i = 0; i < pl_data.size(); i++) begin
      bit ok = 0;
      pld_data = pl_data[i]; pld_keep = pl_keep[i];
      pld_last = (i == pl_data.size() - 1); pld_valid = 1'b1;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (pld_ready === 1'b1) begin ok = 1; break; end
      end
      if (!ok) begin
        n_checks++;
        $display("FAIL pld_timeout: got no pld_ready at beat %0d, need ready", i);
        break;
      end
      @(posedge clk); #1;
    end
    pld_valid = 1'b0; pld_last = 1'b0;
  endtask

  task automatic wait_tx_drain();
    bit ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    n_checks++;
    if (!ok || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL tx_drain: got left=%0d busy=%b done=%b, need 0 1 0", exp_q.size(), busy, done);
    else n_pass++;
  endtask

  task automatic send_rx(input logic [47:0] mac, input logic [15:0] drank, input logic [7:0] srank,
                         input logic [7:0] typ, input int n);
    logic [63:0] b[5];
    b[0] = {mac, 16'h1234};
    b[1] = {32'h0, 16'h88B5, 8'h00, typ};
    b[2] = 64'h0;
    b[3] = {drank, srank, typ, 32'h0};
    b[4] = b[3];
    for (int i = 0; i < n; i++) begin
      stream_in_data  = (n == 3 && i == 2) ? b[3] : b[i];
      stream_in_last  = (i == n - 1);
      stream_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    stream_in_valid = 1'b0; stream_in_last = 1'b0;
  endtask

  task automatic check_ack(input string name, input logic exp_done, input logic exp_busy);
    n_checks++;
    if (done !== exp_done || busy !== exp_busy)
      $display("FAIL %s: got done=%b busy=%b, need done=%b busy=%b", name, done, busy, exp_done, exp_busy);
    else n_pass++;
    if (exp_done) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0)
        $display("FAIL %s_pulse: got done=%b next cycle, need 0", name, done);
      else n_pass++;
    end
  endtask

  task automatic fill_payload(input int n, input logic [7:0] last_keep);
    pl_data.delete(); pl_keep.delete();
    for (int i = 0; i < n; i++) begin
      pl_data.push_back({$urandom(), $urandom()});
      pl_keep.push_back(i == n - 1 ? last_keep : 8'hFF);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (stream_out_valid !== 1'b0 || cmd_ready !== 1'b0)
        $display("FAIL reset_during: got valid=%b cmd_ready=%b, need 0 0", stream_out_valid, cmd_ready);
      else n_pass++;
    end
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pld_ready !== 1'b0 ||
        stream_in_ready !== 1'b1 || stream_out_data !== 64'h0 || stream_out_keep !== 8'h0 ||
        stream_out_last !== 1'b0)
      $display("FAIL reset_after: got rdy=%b busy=%b done=%b pr=%b ir=%b d=%h k=%h l=%b, need 1 0 0 0 1 0 0 0",
               cmd_ready, busy, done, pld_ready, stream_in_ready, stream_out_data, stream_out_keep, stream_out_last);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_single_send();
    set_cmd(16'h0001, 8'h00, 32'd2, 48'hfa163e55ca02, 48'h0cc47a88c047, 32'h0, 32'h0);
    pl_data.delete(); pl_keep.delete();
    pl_data.push_back(64'h41000000_00000000); pl_keep.push_back(8'hFF);
    exp_q.push_back(hb(64'hfa163e55ca020cc4, 1'b0));
    exp_q.push_back(hb(64'h7a88c047_88b5_0001, 1'b0));
    exp_q.push_back(hb(64'h0, 1'b0));
    exp_q.push_back(hb(64'h0001_0001_00000002, 1'b0));
    push_payload();
    exp_q.push_back(hb(64'hfa163e55ca020cc4, 1'b0));
    exp_q.push_back(hb(64'h7a88c047_88b5_0002, 1'b0));
    exp_q.push_back(hb(64'h0, 1'b0));
    exp_q.push_back(hb(64'h0001_0002_00000000, 1'b1));
    issue_cmd();
    drive_payload();
    wait_tx_drain();
  endtask

  task automatic test_done_ack();
    send_rx(48'h0cc47a88c047, 16'h0000, 8'h01, 8'h03, 4);
    check_ack("done_ack", 1'b1, 1'b0);
    send_rx(48'h0cc47a88c047, 16'h0000, 8'h01, 8'h03, 4);
    check_ack("ack_in_idle", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    pl_data.delete(); pl_keep.delete();
    pl_data.push_back(64'hdeadbeefdeadbeef); pl_keep.push_back(8'hFF);
    push_frame(8'h01, 32'd2); push_payload(); push_frame(8'h02, 32'd0);
    issue_cmd();
    drive_payload();
    wait_tx_drain();
    send_rx(48'h0cc47a88c047, 16'h0000, 8'h01, 8'h03, 4);
    check_ack("b2b_ack", 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    set_cmd(16'h0305, 8'h07, 32'd6, 48'h112233445566, 48'ha1b2c3d4e5f6, 32'h0a000001, 32'h0a000002);
    fill_payload(3, 8'hFF);
    push_frame(8'h01, 32'd6); push_payload(); push_frame(8'h02, 32'd0);
    bp = 1'b1;
    issue_cmd();
    drive_payload();
    wait_tx_drain();
    bp = 1'b0; stream_out_ready = 1'b1;
    send_rx(48'ha1b2c3d4e5f6, 16'h0007, 8'h05, 8'h03, 4);
    check_ack("bp_ack", 1'b1, 1'b0);
  endtask

  task automatic test_bad_ack();
    set_cmd(16'h0102, 8'h04, 32'd2, 48'h020000000001, 48'h020000000002, 32'hc0a80001, 32'hc0a80002);
    fill_payload(1, 8'h0F);
    push_frame(8'h01, 32'd2); push_payload(); push_frame(8'h02, 32'd0);
    issue_cmd();
    drive_payload();
    wait_tx_drain();
    send_rx(48'h020000000002, 16'h0004, 8'h02, 8'h01, 4);
    check_ack("bad_type", 1'b0, 1'b1);
    send_rx(48'h020000000002, 16'h0004, 8'h01, 8'h03, 4);
    check_ack("bad_rank", 1'b0, 1'b1);
    send_rx(48'h020000000002, 16'h0104, 8'h02, 8'h03, 4);
    check_ack("bad_rank_hi", 1'b0, 1'b1);
    send_rx(48'h020000000009, 16'h0004, 8'h02, 8'h03, 4);
    check_ack("bad_mac", 1'b0, 1'b1);
    send_rx(48'h020000000002, 16'h0004, 8'h02, 8'h03, 3);
    check_ack("short_frame", 1'b0, 1'b1);
    send_rx(48'h020000000002, 16'h0004, 8'h02, 8'h03, 5);
    check_ack("long_frame", 1'b0, 1'b1);
    send_rx(48'h020000000002, 16'h0004, 8'h02, 8'h03, 4);
    check_ack("good_after_bad", 1'b1, 1'b0);
  endtask

  task automatic test_long_payload();
    set_cmd(16'h0010, 8'h03, 32'd35, 48'h0a0b0c0d0e0f, 48'h101112131415, 32'h01020304, 32'h05060708);
    fill_payload(18, 8'h0F);
    push_frame(8'h01, 32'd35); push_payload(); push_frame(8'h02, 32'd0);
    tx_beats = 0;
    issue_cmd();
    drive_payload();
    wait_tx_drain();
    n_checks++;
    if (tx_beats != 26) $display("FAIL long_beat_count: got %0d, need 26", tx_beats);
    else n_pass++;
    send_rx(48'h101112131415, 16'h0003, 8'h10, 8'h03, 4);
    check_ack("long_ack", 1'b1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    stream_out_ready = 1'b0;
    set_cmd(16'h0001, 8'h02, 32'd4, 48'h00aa00bb00cc, 48'h00dd00ee00ff, 32'h0, 32'h1);
    push_frame(8'h01, 32'd4);
    issue_cmd();
    @(posedge clk); #1;
    aresetn = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (stream_out_valid !== 1'b0 || busy !== 1'b0 || stream_out_last !== 1'b0)
      $display("FAIL reset_midframe: got valid=%b busy=%b last=%b, need 0 0 0",
               stream_out_valid, busy, stream_out_last);
    else n_pass++;
    exp_q.delete();
    aresetn = 1'b1;
    stream_out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    cmd_valid = 1'b0; pld_valid = 1'b0; pld_last = 1'b0; pld_data = '0; pld_keep = '0;
    stream_out_ready = 1'b1;
    stream_in_valid = 1'b0; stream_in_last = 1'b0; stream_in_data = '0; stream_in_keep = 8'hFF;
    set_cmd('0, '0, '0, '0, '0, '0, '0);
    test_reset();
    test_single_send();
    test_done_ack();
    test_back_to_back();
    test_backpressure();
    test_bad_ack();
    test_long_payload();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
